// File: rtl/simon_pkg.sv
// Shared Simon definitions: color codes used by the game and the button front end,
// the button conditioner state encoding, and a one-hot to color-code helper.
package simon_pkg;

    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_BLUE   = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESS,
        HOLD,
        RELEASE
    } btn_state_t;

    // Button vectors are ordered {yellow, green, blue, red}, so bit index equals color code.
    function automatic logic [1:0] encode_color(input logic [3:0] onehot);
        logic [1:0] code;
        case (onehot)
            4'b0001: code = COLOR_RED;
            4'b0010: code = COLOR_BLUE;
            4'b0100: code = COLOR_GREEN;
            4'b1000: code = COLOR_YELLOW;
            default: code = COLOR_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// Two-stage synchronizer for asynchronous levels, built from two-phase master/slave flops:
// masters capture at the end of ph1, slaves transfer during ph2.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_m;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2_m;

    always_ff @(negedge ph1) begin
        if (reset) begin
            s1_m <= '0;
            s2_m <= '0;
        end else begin
            s1_m <= d;
            s2_m <= s1;
        end
    end

    always_ff @(posedge ph2) begin
        s1 <= s1_m;
        q  <= s2_m;
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects the four Simon buttons into single-cycle press events.
// Optional stuck-button detection is compiled in with `define STUCK_DETECT_EN.
module button_conditioner
    import simon_pkg::*;
#(
    parameter int DB_CYCLES  = 8,
    parameter int CNT_W      = 4,
    parameter int HOLD_LIMIT = 1023
) (
    input  logic       ph1,
    input  logic       ph2,
    input  logic       reset,
    input  logic       red_raw,
    input  logic       yellow_raw,
    input  logic       green_raw,
    input  logic       blue_raw,
    output logic       press_valid,
    output logic [1:0] press_code,
    output logic       r_p,
    output logic       y_p,
    output logic       g_p,
    output logic       b_p,
    output logic       stuck
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || DB_CYCLES > 15 || (2 ** CNT_W) <= DB_CYCLES || HOLD_LIMIT < 1) begin : g_bad_param
        $error("button_conditioner: illegal parameter combination");
    end

    logic [3:0] raw_vec;
    logic [3:0] s;

    assign raw_vec = {yellow_raw, green_raw, blue_raw, red_raw};

    sync2 #(.WIDTH(4)) u_sync (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .d     (raw_vec),
        .q     (s)
    );

    btn_state_t       state, state_m, state_next;
    logic [3:0]       cand, cand_m, cand_next;
    logic [CNT_W-1:0] cnt, cnt_m, cnt_next;

`ifdef STUCK_DETECT_EN
    localparam int HC_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_LIMIT);

    logic [HC_W-1:0] hold_cnt, hold_cnt_m, hold_cnt_next;

    // Cleared on entry from PRESS and on the way back to IDLE; a RELEASE bounce keeps the count.
    always_comb begin
        hold_cnt_next = hold_cnt;
        if (state == PRESS) begin
            hold_cnt_next = '0;
        end else if (state == HOLD && hold_cnt != HOLD_MAX) begin
            hold_cnt_next = hold_cnt + 1'b1;
        end else if (state == RELEASE && state_next == IDLE) begin
            hold_cnt_next = '0;
        end
    end

    always_ff @(negedge ph1) begin
        if (reset) hold_cnt_m <= '0;
        else       hold_cnt_m <= hold_cnt_next;
    end

    always_ff @(posedge ph2) begin
        hold_cnt <= hold_cnt_m;
    end
`endif

    // Reset parks the FSM in HOLD so a button held through reset must be released first.
    always_ff @(negedge ph1) begin
        if (reset) begin
            state_m <= HOLD;
            cand_m  <= '0;
            cnt_m   <= '0;
        end else begin
            state_m <= state_next;
            cand_m  <= cand_next;
            cnt_m   <= cnt_next;
        end
    end

    always_ff @(posedge ph2) begin
        state <= state_m;
        cand  <= cand_m;
        cnt   <= cnt_m;
    end

    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if ($onehot(s)) begin
                    cand_next  = s;
                    cnt_next   = CNT_ONE;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s != cand) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESS;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESS: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (s == '0) begin
                    cnt_next   = CNT_ONE;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (s != '0) begin
                    state_next = HOLD;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    always_comb begin
        press_valid = (state == PRESS);
        press_code  = press_valid ? encode_color(cand) : COLOR_RED;
        r_p         = press_valid & cand[0];
        b_p         = press_valid & cand[1];
        g_p         = press_valid & cand[2];
        y_p         = press_valid & cand[3];
`ifdef STUCK_DETECT_EN
        stuck       = (hold_cnt == HOLD_MAX);
`else
        stuck       = 1'b0;
`endif
    end

endmodule
